// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between two requesters, the round-robin arbiter and the downstream sink.
interface rr_mux_arbiter_if #(parameter int DATA_WIDTH = 8);
  logic                  req_0, req_1;
  logic [DATA_WIDTH-1:0] din_0, din_1;
  logic                  last_0, last_1;
  logic                  out_ready;
  logic                  gnt_0, gnt_1;
  logic                  sel;
  logic [DATA_WIDTH-1:0] mux_out;
  logic                  out_valid;

  modport master (
    output req_0, req_1, din_0, din_1, last_0, last_1, out_ready,
    input  gnt_0, gnt_1, sel, mux_out, out_valid
  );

  modport slave (
    input  req_0, req_1, din_0, din_1, last_0, last_1, out_ready,
    output gnt_0, gnt_1, sel, mux_out, out_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter with burst limit, driving a registered-select 2:1 data mux.
module rr_mux_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic clk,
  input  logic reset,
  rr_mux_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t                r_state, w_next;
  logic                  r_sel, r_prio, w_prio_nxt;
  logic [3:0]            r_beat_cnt, w_cnt_nxt;
  logic                  w_valid, w_xfer, w_last, w_burst_end;
  logic [DATA_WIDTH-1:0] w_mux;

  assign w_valid     = ((r_state == GNT0) & bus.req_0) | ((r_state == GNT1) & bus.req_1);
  assign w_xfer      = w_valid & bus.out_ready;
  assign w_last      = (r_state == GNT1) ? bus.last_1 : bus.last_0;
  // last is only honoured on an accepted beat, so a stalled beat never ends the burst
  assign w_burst_end = w_xfer & (w_last | (r_beat_cnt == LAST_BEAT));

  always_comb begin
    w_next     = r_state;
    w_prio_nxt = r_prio;
    w_cnt_nxt  = r_beat_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (bus.req_0 && bus.req_1) w_next = r_prio ? GNT1 : GNT0;
        else if (bus.req_0)         w_next = GNT0;
        else if (bus.req_1)         w_next = GNT1;
      end
      GNT0: begin
        if (w_burst_end || !bus.req_0) begin
          w_prio_nxt = 1'b1;
          w_cnt_nxt  = '0;
          w_next     = bus.req_1 ? GNT1 : (bus.req_0 ? GNT0 : IDLE);
        end else if (w_xfer) begin
          w_cnt_nxt = r_beat_cnt + 4'd1;
        end
      end
      GNT1: begin
        if (w_burst_end || !bus.req_1) begin
          w_prio_nxt = 1'b0;
          w_cnt_nxt  = '0;
          w_next     = bus.req_0 ? GNT0 : (bus.req_1 ? GNT1 : IDLE);
        end else if (w_xfer) begin
          w_cnt_nxt = r_beat_cnt + 4'd1;
        end
      end
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_beat_cnt <= '0;
      r_sel      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_prio     <= w_prio_nxt;
      r_beat_cnt <= w_cnt_nxt;
      // select follows the owner; idle keeps the last owner's side
      case (w_next)
        GNT0:    r_sel <= 1'b0;
        GNT1:    r_sel <= 1'b1;
        default: r_sel <= r_sel;
      endcase
    end
  end

  assign w_mux         = (r_state == IDLE) ? '0 : (r_sel ? bus.din_1 : bus.din_0);
  assign bus.mux_out   = w_mux;
  assign bus.out_valid = w_valid;
  assign bus.gnt_0     = (r_state == GNT0);
  assign bus.gnt_1     = (r_state == GNT1);
  assign bus.sel       = r_sel;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: burst-4 and burst-1 instances checked against a grant-owner model each cycle.
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   run = 0;

  rr_mux_arbiter_if #(.DATA_WIDTH(8)) bus ();
  rr_mux_arbiter_if #(.DATA_WIDTH(8)) bus1 ();

  rr_mux_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  rr_mux_arbiter #(.DATA_WIDTH(8), .MAX_BURST(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  assign bus1.req_0     = bus.req_0;
  assign bus1.req_1     = bus.req_1;
  assign bus1.din_0     = bus.din_0;
  assign bus1.din_1     = bus.din_1;
  assign bus1.last_0    = bus.last_0;
  assign bus1.last_1    = bus.last_1;
  assign bus1.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the output, beats already taken in this burst, whose turn on a tie.
  int m_own[2]  = '{-1, -1};
  int m_cnt[2]  = '{0, 0};
  int m_prio[2] = '{0, 0};
  int m_sel[2]  = '{0, 0};
  int m_max[2]  = '{4, 1};

  task automatic model_step(input int k);
    logic rq[2];
    logic lt[2];
    int   o;
    bit   took;
    rq[0] = bus.req_0;  rq[1] = bus.req_1;
    lt[0] = bus.last_0; lt[1] = bus.last_1;
    o = m_own[k];
    if (o < 0) begin
      if (rq[0] && rq[1]) o = m_prio[k];
      else if (rq[0])     o = 0;
      else if (rq[1])     o = 1;
      m_cnt[k] = 0;
    end else begin
      took = rq[o] && bus.out_ready;
      if (!rq[o] || (took && (lt[o] || (m_cnt[k] + 1 == m_max[k])))) begin
        m_prio[k] = 1 - o;
        m_cnt[k]  = 0;
        if (rq[1-o])    o = 1 - o;
        else if (!rq[o]) o = -1;
      end else if (took) begin
        m_cnt[k]++;
      end
    end
    m_own[k] = o;
    if (o >= 0) m_sel[k] = o;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_own[k] = -1; m_cnt[k] = 0; m_prio[k] = 0; m_sel[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic cmp(input int k, input logic g0, input logic g1, input logic s,
                     input logic [7:0] mo, input logic ov);
    logic [7:0] e_mux;
    logic       e_ov;
    e_ov  = (m_own[k] == 0) ? bus.req_0 : (m_own[k] == 1) ? bus.req_1 : 1'b0;
    e_mux = (m_own[k] < 0) ? 8'h00 : (m_sel[k] == 1) ? bus.din_1 : bus.din_0;
    chk($sformatf("m%0d_gnt_0", k), 32'(g0), 32'(m_own[k] == 0));
    chk($sformatf("m%0d_gnt_1", k), 32'(g1), 32'(m_own[k] == 1));
    chk($sformatf("m%0d_sel", k), 32'(s), 32'(m_sel[k]));
    chk($sformatf("m%0d_mux_out", k), 32'(mo), 32'(e_mux));
    chk($sformatf("m%0d_out_valid", k), 32'(ov), 32'(e_ov));
  endtask

  always @(negedge clk) begin
    if (run) begin
      cmp(0, bus.gnt_0, bus.gnt_1, bus.sel, bus.mux_out, bus.out_valid);
      cmp(1, bus1.gnt_0, bus1.gnt_1, bus1.sel, bus1.mux_out, bus1.out_valid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // {req_0, req_1, last_0, last_1, out_ready}
  logic [4:0] vec [0:19] = '{5'b11001, 5'b11001, 5'b11101, 5'b11011, 5'b11000,
                             5'b11000, 5'b11001, 5'b10001, 5'b01001, 5'b01011,
                             5'b11111, 5'b11111, 5'b00001, 5'b11001, 5'b11001,
                             5'b11001, 5'b11001, 5'b11001, 5'b01000, 5'b00000};

  initial begin
    bus.req_0 = 1'b1; bus.req_1 = 1'b1;
    bus.din_0 = 8'hA0; bus.din_1 = 8'hB1;
    bus.last_0 = 1'b0; bus.last_1 = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state with both requests already pending
    tick();
    run = 1;
    chk("rst_gnt_0", 32'(bus.gnt_0), 0);
    chk("rst_gnt_1", 32'(bus.gnt_1), 0);
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_mux_out", 32'(bus.mux_out), 0);
    tick();
    reset = 1'b0;

    // First tie after reset goes to requester 0, then bursts alternate
    tick();
    chk("tie_gnt_0", 32'(bus.gnt_0), 1);
    chk("tie_sel", 32'(bus.sel), 0);
    chk("tie_mux_out", 32'(bus.mux_out), 32'h A0);
    for (int i = 0; i < 16; i++) begin
      chk("alt4_valid", 32'(bus.out_valid), 1);
      chk("alt4_src", 32'(bus.gnt_1), 32'((i / 4) % 2));
      chk("alt1_src", 32'(bus1.gnt_1), 32'(i % 2));
      tick();
    end

    // Early last on the second beat hands over to requester 1
    bus.req_1 = 1'b0;
    tick();
    bus.req_1 = 1'b1; bus.last_0 = 1'b1;
    tick();
    bus.last_0 = 1'b0; bus.req_0 = 1'b0;
    chk("last_gnt_1", 32'(bus.gnt_1), 1);
    chk("last_gnt_0", 32'(bus.gnt_0), 0);
    chk("last_prio", 32'(dut.r_prio), 1);

    // Stall mid-burst: grant, select and beat count hold
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_gnt_1", 32'(bus.gnt_1), 1);
      chk("stall_sel", 32'(bus.sel), 1);
      chk("stall_cnt", 32'(dut.r_beat_cnt), 1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("resume_cnt", 32'(dut.r_beat_cnt), 2);
    tick();
    tick();
    chk("resume_regrant", 32'(bus.gnt_1), 1);
    chk("resume_cnt_clr", 32'(dut.r_beat_cnt), 0);

    // Requester 0 drops mid-burst with nobody else waiting
    bus.req_1 = 1'b0;
    tick();
    bus.req_0 = 1'b1;
    tick();
    tick();
    bus.req_0 = 1'b0;
    #1;
    chk("drop_valid_now", 32'(bus.out_valid), 0);
    tick();
    chk("drop_gnt_0", 32'(bus.gnt_0), 0);
    chk("drop_gnt_1", 32'(bus.gnt_1), 0);
    chk("drop_mux_out", 32'(bus.mux_out), 0);
    chk("drop_valid", 32'(bus.out_valid), 0);

    // Asynchronous reset during a requester-1 burst
    bus.req_1 = 1'b1;
    tick();
    tick();
    #1;
    reset = 1'b1;
    bus.req_0 = 1'b1;
    #1;
    chk("arst_gnt_1", 32'(bus.gnt_1), 0);
    chk("arst_sel", 32'(bus.sel), 0);
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_mux_out", 32'(bus.mux_out), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("arst_tie_gnt_0", 32'(bus.gnt_0), 1);
    chk("arst_tie_mux", 32'(bus.mux_out), 32'h A0);

    // Mixed directed vectors, checked by the per-cycle model
    for (int i = 0; i < 20; i++) begin
      {bus.req_0, bus.req_1, bus.last_0, bus.last_1, bus.out_ready} = vec[i];
      bus.din_0 = 8'(8'h10 + i);
      bus.din_1 = 8'(8'h80 + i);
      tick();
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
